// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the multi-cycle core.
//   - 7-bit opcode constants for the instruction classes the sequencer decodes
//   - sequencer state encoding (FETCH=0 .. TRAP=5)
//   - is_known_op(): true for every opcode class the sequencer executes
package riscv_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } seq_state_t;

  function automatic logic is_known_op(input logic [6:0] op);
    return (op == R_TYPE) || (op == I_TYPE) || (op == LOAD) || (op == STORE) ||
           (op == BRANCH) || (op == JAL) || (op == JALR);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_retire_counter.sv
// retire_counter: CNT_W-bit enable-increment counter, wraps modulo 2^CNT_W.
// Ports:
//   clk    in   core clock
//   rst_n  in   asynchronous active-low reset (clears count)
//   en     in   increment this cycle
//   count  out  current count
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  r_count <= '0;
    else if (en) r_count <= r_count + 1'b1;
  end

  assign count = r_count;

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: steps each RV32I instruction through FETCH, DECODE,
// EXECUTE, MEM and WB and issues single-cycle datapath strobes.
// Optional feature macro: SEQ_TRAP_EN (unknown opcodes trap in DECODE and
// the sticky trap output exists; otherwise they retire as NOP).
// Ports:
//   clk, rst_n             clock, async active-low reset
//   run                    permit a new instruction fetch
//   opcode                 opcode of the latched instruction register
//   branch_taken           branch compare result, valid in EXECUTE
//   imem_req / imem_ready  instruction fetch handshake
//   ir_load                latch fetched word into the instruction register
//   dmem_req/dmem_we/dmem_ready  data memory handshake (we=1 for STORE)
//   rf_we                  register-file write strobe
//   pc_load / pc_sel       PC update; sel 0 = PC+4, 1 = branch/jump target
//   state                  current state (debug)
//   instret                retired-instruction count
//   trap                   sticky illegal-opcode flag (SEQ_TRAP_EN only)
module multicycle_sequencer
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             rf_we,
  output logic             pc_load,
  output logic             pc_sel,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
`ifdef SEQ_TRAP_EN
  ,
  output logic             trap
`endif
);

  seq_state_t r_state;
  seq_state_t w_next;
  logic       r_imem_pend;

  logic w_imem_req, w_ir_load, w_dmem_req, w_dmem_we;
  logic w_rf_we, w_pc_load, w_pc_sel;

  // State register and outstanding-fetch flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_imem_pend <= 1'b0;
    end else begin
      r_state     <= w_next;
      // A raised fetch request stays up until imem_ready, even if run drops.
      r_imem_pend <= w_imem_req & ~imem_ready;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:   if (w_imem_req && imem_ready) w_next = S_DECODE;
      S_DECODE: begin
`ifdef SEQ_TRAP_EN
        if (!is_known_op(opcode)) w_next = S_TRAP;
        else                      w_next = S_EXECUTE;
`else
        w_next = S_EXECUTE;
`endif
      end
      S_EXECUTE: begin
        case (opcode)
          R_TYPE, I_TYPE: w_next = S_WB;
          LOAD, STORE:    w_next = S_MEM;
          default:        w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) w_next = (opcode == LOAD) ? S_WB : S_FETCH;
      end
      S_WB:      w_next = S_FETCH;
      S_TRAP:    w_next = S_TRAP;
      default:   w_next = S_FETCH;
    endcase
  end

  // Strobe decode
  always_comb begin
    w_imem_req = 1'b0;
    w_ir_load  = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;
    w_rf_we    = 1'b0;
    w_pc_load  = 1'b0;
    w_pc_sel   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = run | r_imem_pend;
        w_ir_load  = w_imem_req & imem_ready;
      end
      S_EXECUTE: begin
        case (opcode)
          BRANCH: begin
            w_pc_load = 1'b1;
            w_pc_sel  = branch_taken;
          end
          JAL, JALR: begin
            w_rf_we   = 1'b1;
            w_pc_load = 1'b1;
            w_pc_sel  = 1'b1;
          end
          R_TYPE, I_TYPE, LOAD, STORE: ;
          // Unknown opcode retires as a NOP (only reachable without traps).
          default:  w_pc_load = 1'b1;
        endcase
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (opcode == STORE);
        // A store retires in MEM; a load still needs its WB cycle.
        w_pc_load  = dmem_ready & (opcode != LOAD);
      end
      S_WB: begin
        w_rf_we   = 1'b1;
        w_pc_load = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are forced low for the whole time reset is held.
  assign imem_req = rst_n & w_imem_req;
  assign ir_load  = rst_n & w_ir_load;
  assign dmem_req = rst_n & w_dmem_req;
  assign dmem_we  = rst_n & w_dmem_we;
  assign rf_we    = rst_n & w_rf_we;
  assign pc_load  = rst_n & w_pc_load;
  assign pc_sel   = rst_n & w_pc_sel;
  assign state    = rst_n ? r_state : 3'd0;

`ifdef SEQ_TRAP_EN
  assign trap = rst_n & (r_state == S_TRAP);
`endif

  retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pc_load),
    .count (instret)
  );

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  localparam int CNT_W = 32;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic             clk;
  logic             rst_n;
  logic             run;
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             imem_req;
  logic             imem_ready;
  logic             ir_load;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ready;
  logic             rf_we;
  logic             pc_load;
  logic             pc_sel;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;
`ifdef SEQ_TRAP_EN
  logic             trap;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_sequencer #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .ir_load      (ir_load),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ready   (dmem_ready),
    .rf_we        (rf_we),
    .pc_load      (pc_load),
    .pc_sel       (pc_sel),
    .state        (state),
    .instret      (instret)
`ifdef SEQ_TRAP_EN
    ,
    .trap         (trap)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=still running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; opcode = OP_JAL; branch_taken = 1'b1;
    settle();
    check("rst imem_req", 32'(imem_req), 0);
    check("rst ir_load",  32'(ir_load),  0);
    check("rst dmem_req", 32'(dmem_req), 0);
    check("rst pc_load",  32'(pc_load),  0);
    check("rst state",    32'(state),    0);
    check("rst instret",  instret,       0);
    tick();
    rst_n = 1'b1;
    run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    settle();
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = OP_I; branch_taken = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    do_reset();

    // ADDI, zero-wait
    opcode = OP_I; run = 1'b1; imem_ready = 1'b1; settle();
    check("addi c0 state",    32'(state),    0);
    check("addi c0 imem_req", 32'(imem_req), 1);
    check("addi c0 ir_load",  32'(ir_load),  1);
    tick(); run = 1'b0; imem_ready = 1'b0; settle();
    check("addi c1 state",   32'(state),   1);
    check("addi c1 pc_load", 32'(pc_load), 0);
    tick(); settle();
    check("addi c2 state",   32'(state),   2);
    check("addi c2 rf_we",   32'(rf_we),   0);
    tick(); settle();
    check("addi c3 state",   32'(state),   4);
    check("addi c3 rf_we",   32'(rf_we),   1);
    check("addi c3 pc_load", 32'(pc_load), 1);
    check("addi c3 pc_sel",  32'(pc_sel),  0);
    check("addi c3 instret", instret,      0);
    tick(); settle();
    check("addi c4 state",    32'(state),    0);
    check("addi c4 instret",  instret,       1);
    check("addi c4 idle req", 32'(imem_req), 0);

    // LOAD with dmem_ready delayed 3 cycles
    do_reset();
    opcode = OP_LD; run = 1'b1; imem_ready = 1'b1; settle();
    check("ld c0 ir_load", 32'(ir_load), 1);
    tick(); run = 1'b0; imem_ready = 1'b0; settle();
    check("ld c1 state", 32'(state), 1);
    tick(); settle();
    check("ld c2 state",   32'(state),   2);
    check("ld c2 pc_load", 32'(pc_load), 0);
    for (int i = 0; i < 4; i++) begin
      tick(); dmem_ready = (i == 3); settle();
      check("ld mem state",   32'(state),    3);
      check("ld mem dmem_req", 32'(dmem_req), 1);
      check("ld mem dmem_we", 32'(dmem_we),  0);
      check("ld mem pc_load", 32'(pc_load),  0);
    end
    tick(); dmem_ready = 1'b0; settle();
    check("ld wb state",   32'(state),   4);
    check("ld wb rf_we",   32'(rf_we),   1);
    check("ld wb pc_load", 32'(pc_load), 1);
    tick(); settle();
    check("ld done state",   32'(state), 0);
    check("ld done instret", instret,    1);

    // BRANCH taken, then BRANCH not taken
    do_reset();
    opcode = OP_BR; branch_taken = 1'b1; run = 1'b1; imem_ready = 1'b1; settle();
    check("br1 ir_load", 32'(ir_load), 1);
    tick(); run = 1'b0; imem_ready = 1'b0; settle();
    check("br1 dec state", 32'(state), 1);
    tick(); settle();
    check("br1 ex state",   32'(state),   2);
    check("br1 ex pc_load", 32'(pc_load), 1);
    check("br1 ex pc_sel",  32'(pc_sel),  1);
    check("br1 ex rf_we",   32'(rf_we),   0);
    tick(); run = 1'b1; imem_ready = 1'b1; branch_taken = 1'b0; settle();
    check("br2 fetch state", 32'(state),   0);
    check("br2 ir_load",     32'(ir_load), 1);
    check("br2 instret",     instret,      1);
    tick(); run = 1'b0; imem_ready = 1'b0; settle();
    tick(); settle();
    check("br2 ex state",   32'(state),   2);
    check("br2 ex pc_load", 32'(pc_load), 1);
    check("br2 ex pc_sel",  32'(pc_sel),  0);
    tick(); settle();
    check("br2 done instret", instret, 2);

    // run dropped while fetch is outstanding
    do_reset();
    opcode = OP_I; run = 1'b1; settle();
    check("rd c0 imem_req", 32'(imem_req), 1);
    check("rd c0 ir_load",  32'(ir_load),  0);
    tick(); run = 1'b0; settle();
    check("rd c1 imem_req", 32'(imem_req), 1);
    check("rd c1 state",    32'(state),    0);
    tick(); settle();
    check("rd c2 imem_req", 32'(imem_req), 1);
    tick(); imem_ready = 1'b1; settle();
    check("rd c3 ir_load", 32'(ir_load), 1);
    tick(); imem_ready = 1'b0; settle();
    check("rd dec state", 32'(state), 1);
    tick(); tick(); settle();
    check("rd wb pc_load", 32'(pc_load), 1);
    tick(); imem_ready = 1'b1; settle();
    check("rd idle imem_req", 32'(imem_req), 0);
    check("rd idle ir_load",  32'(ir_load),  0);
    tick(); imem_ready = 1'b0; settle();
    check("rd idle state",   32'(state), 0);
    check("rd idle instret", instret,    1);

    // JAL, zero-wait STORE, then reset during a stalled STORE
    do_reset();
    opcode = OP_JAL; run = 1'b1; imem_ready = 1'b1;
    tick(); run = 1'b0; imem_ready = 1'b0;
    tick(); settle();
    check("jal ex rf_we",   32'(rf_we),   1);
    check("jal ex pc_load", 32'(pc_load), 1);
    check("jal ex pc_sel",  32'(pc_sel),  1);
    tick(); settle();
    check("jal instret", instret, 1);
    opcode = OP_ST; run = 1'b1; imem_ready = 1'b1; settle();
    check("st0 ir_load", 32'(ir_load), 1);
    tick(); run = 1'b0; imem_ready = 1'b0;
    tick(); settle();
    check("st0 ex pc_load", 32'(pc_load), 0);
    tick(); dmem_ready = 1'b1; settle();
    check("st0 mem state",   32'(state),    3);
    check("st0 mem dmem_we", 32'(dmem_we),  1);
    check("st0 mem pc_load", 32'(pc_load),  1);
    check("st0 mem pc_sel",  32'(pc_sel),   0);
    tick(); dmem_ready = 1'b0; settle();
    check("st0 done state",   32'(state), 0);
    check("st0 done instret", instret,    2);
    run = 1'b1; imem_ready = 1'b1;
    tick(); run = 1'b0; imem_ready = 1'b0;
    tick(); tick(); settle();
    check("st1 mem dmem_req", 32'(dmem_req), 1);
    check("st1 mem dmem_we",  32'(dmem_we),  1);
    check("st1 mem pc_load",  32'(pc_load),  0);
    #2; rst_n = 1'b0; #1;
    check("st1 rst dmem_req", 32'(dmem_req), 0);
    check("st1 rst state",    32'(state),    0);
    check("st1 rst instret",  instret,       0);
    @(posedge clk); #1;
    rst_n = 1'b1; run = 1'b1; settle();
    check("st1 resume state",    32'(state),    0);
    check("st1 resume imem_req", 32'(imem_req), 1);

    // Unknown opcode
    do_reset();
    opcode = OP_BAD; run = 1'b1; imem_ready = 1'b1; settle();
    check("bad ir_load", 32'(ir_load), 1);
    tick(); run = 1'b0; imem_ready = 1'b0; settle();
    check("bad dec state", 32'(state), 1);
    tick(); settle();
`ifdef SEQ_TRAP_EN
    check("bad trap state",   32'(state),   5);
    check("bad trap flag",    32'(trap),    1);
    check("bad trap pc_load", 32'(pc_load), 0);
    tick(); run = 1'b1; settle();
    check("bad sticky state",    32'(state),    5);
    check("bad sticky trap",     32'(trap),     1);
    check("bad sticky imem_req", 32'(imem_req), 0);
    check("bad sticky instret",  instret,       0);
`else
    check("bad nop state",   32'(state),   2);
    check("bad nop pc_load", 32'(pc_load), 1);
    check("bad nop pc_sel",  32'(pc_sel),  0);
    check("bad nop rf_we",   32'(rf_we),   0);
    tick(); settle();
    check("bad nop fetch",   32'(state), 0);
    check("bad nop instret", instret,    1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
